cpu_insn_arbiter: RTL and testbench
===================================

# cpu_insn_arbiter

- Shares the single instruction/readback port of the game-logic CPU wrapper between two requesters:
  - requester 0: note spawner (needs a new random note)
  - requester 1: hit judge (checks whether the lowest note is close enough on a key press)
- Each request is an instruction word plus a result-register index. The block issues the instruction for one cycle, waits the CPU pipeline latency, reads the result register, and returns the value tagged with the requester ID.
- It sits between the VGA game controller logic and the CPU wrapper, and replaces the ad-hoc cycle countdown previously done inline.

## Interface
Parameters:
- LATENCY, 6, cycles between instruction issue and result-register read; legal range 1..31
- INSN_W, 32, instruction width
- DATA_W, 32, result data width

Ports:
- clk  in  1  100 MHz system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req0_valid  in  1  spawner request
- req0_insn  in  INSN_W  spawner instruction; held stable while req0_valid && !req0_ready
- req0_rd  in  5  spawner result register index
- req0_ready  out  1  spawner request accepted this cycle when high with req0_valid
- req1_valid / req1_insn / req1_rd / req1_ready: same as requester 0, for the hit judge
- cpu_insn  out  INSN_W  instruction to CPU wrapper
- cpu_insn_en  out  1  one-cycle instruction strobe
- cpu_rd_sel  out  5  register index to read
- cpu_rd_en  out  1  read enable
- cpu_rd_data  in  DATA_W  register value, valid in the same cycle as cpu_rd_en
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_W  result value; holds until the next response
- busy  out  1  high in every state except IDLE

## Operation
States: IDLE, ISSUE, WAIT, READ, RESP.

- **IDLE:** grant is computed combinationally from the valids and the priority rule. Only the granted requester's ready is high; both readies are 0 in every other state.
  - On valid && ready: latch insn, rd and id; go to ISSUE.
- **ISSUE:** cpu_insn = latched insn, cpu_insn_en = 1. Load wait counter with LATENCY-1; go to WAIT.
- **WAIT:** decrement the counter each cycle. At 0, go to READ (WAIT lasts exactly LATENCY cycles).
- **READ:** cpu_rd_en = 1, cpu_rd_sel = latched rd. Sample cpu_rd_data into rsp_data at the clock edge; go to RESP.
- **RESP:** rsp_valid = 1, rsp_id = latched id; go to IDLE.
- Outside ISSUE, cpu_insn = 0 and cpu_insn_en = 0. Outside READ, cpu_rd_sel = 0 and cpu_rd_en = 0.
- Simultaneous valids in IDLE: resolved by the priority rule (see Configuration). The losing request stays pending; its ready is low and its valid must be held.
- A valid arriving in any non-IDLE state is not accepted until the next IDLE cycle.
- Deasserting valid before acceptance: legal. Nothing is issued.
- Reset (reset = 0) in any state, mid-operation: abort the transaction without a response and return to IDLE. Round-robin pointer favors requester 0.
- Reset values: all outputs 0; rsp_data = 0; counter = 0; latched fields = 0.

## Timing
- Acceptance in cycle c0 produces:
  - ISSUE at c1
  - WAIT at c2 .. c1+LATENCY
  - READ at c2+LATENCY
  - rsp_valid at c3+LATENCY
- Back-to-back requests: earliest next acceptance at c4+LATENCY, so throughput is 1 transaction per LATENCY+4 cycles.
- With LATENCY = 6: response in cycle 9 after acceptance, next acceptance at cycle 10.
- Counter width is 5 bits; LATENCY outside 1..31 is illegal.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Two-way round robin. A 1-bit pointer names the preferred requester. When both are valid in IDLE, the preferred one wins, and after every grant the pointer moves to the other requester.
  - A single valid requester is always granted.
- Undefined:
  - Fixed priority: requester 0 (spawner) always wins a tie. Requester 1 may starve. No pointer register.

## Test plan
- Single request, LATENCY = 6: req1 with insn = 32'hF0800123, rd = 2, cpu_rd_data = 1 during READ -> cpu_insn_en pulse 1 cycle after accept with insn 32'hF0800123; cpu_rd_en with sel = 2 at accept+8; rsp_valid, rsp_id = 1, rsp_data = 1 at accept+9.
- Tie with ARB_ROUND_ROBIN_EN, both valid continuously -> grants alternate 0,1,0,1; each grant is 10 cycles apart; no overlapping cpu_insn_en.
- Tie without the macro, both valid continuously -> every grant goes to requester 0; req1_ready never high.
- Mid-operation reset: drop reset to 0 during WAIT -> next cycle is IDLE with busy = 0 and all outputs 0; no rsp_valid for the aborted request.
- Boundary LATENCY = 1: request accepted -> cpu_rd_en at accept+3, rsp_valid at accept+4.
- Request during busy: req0 asserted during WAIT of a req1 transaction -> req0_ready stays 0 until IDLE; accepted at the first IDLE cycle; instruction issued unchanged.

Source files
------------

// File: rtl/cpu_insn_arbiter.sv
// Two-requester arbiter for the game-logic CPU instruction/readback port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module cpu_insn_arbiter #(
    parameter int LATENCY = 6,
    parameter int INSN_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [INSN_W-1:0] req0_insn,
    input  logic [4:0]        req0_rd,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [INSN_W-1:0] req1_insn,
    input  logic [4:0]        req1_rd,
    output logic              req1_ready,
    output logic [INSN_W-1:0] cpu_insn,
    output logic              cpu_insn_en,
    output logic [4:0]        cpu_rd_sel,
    output logic              cpu_rd_en,
    input  logic [DATA_W-1:0] cpu_rd_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        READ,
        RESP
    } state_t;

    localparam logic [4:0] WAIT_LOAD = 5'(LATENCY - 1);

    state_t            state;
    state_t            stateNext;
    logic [4:0]        waitCnt;
    logic [INSN_W-1:0] insnQ;
    logic [4:0]        rdQ;
    logic              idQ;
    logic [DATA_W-1:0] rspDataQ;
    logic              gnt1;
    logic              accept;

`ifdef ARB_ROUND_ROBIN_EN
    logic rrPtr;

    // pointer names the requester preferred on the next tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            rrPtr <= 1'b0;
        end else if (accept) begin
            rrPtr <= ~gnt1;
        end
    end

    always_comb begin
        gnt1 = req1_valid && (!req0_valid || rrPtr);
    end
`else
    always_comb begin
        gnt1 = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        stateNext   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        accept      = 1'b0;
        cpu_insn    = '0;
        cpu_insn_en = 1'b0;
        cpu_rd_sel  = '0;
        cpu_rd_en   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_id      = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (reset) begin
                    req0_ready = req0_valid && !gnt1;
                    req1_ready = gnt1;
                    accept     = req0_valid || req1_valid;
                end
                if (accept) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                cpu_insn    = insnQ;
                cpu_insn_en = 1'b1;
                stateNext   = WAIT;
            end
            WAIT: begin
                if (waitCnt == 5'd0) begin
                    stateNext = READ;
                end
            end
            READ: begin
                cpu_rd_sel = rdQ;
                cpu_rd_en  = 1'b1;
                stateNext  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = idQ;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            insnQ    <= '0;
            rdQ      <= '0;
            idQ      <= 1'b0;
            rspDataQ <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                insnQ <= gnt1 ? req1_insn : req0_insn;
                rdQ   <= gnt1 ? req1_rd : req0_rd;
                idQ   <= gnt1;
            end
            // loaded with LATENCY-1 so WAIT spans exactly LATENCY cycles
            if (state == ISSUE) begin
                waitCnt <= WAIT_LOAD;
            end else if (state == WAIT && waitCnt != 5'd0) begin
                waitCnt <= waitCnt - 5'd1;
            end
            if (state == READ) begin
                rspDataQ <= cpu_rd_data;
            end
        end
    end

    assign rsp_data = rspDataQ;

endmodule

// File: tb/tb_cpu_insn_arbiter.sv
// Self-checking bench for cpu_insn_arbiter: directed scenarios plus
// randomized traffic against a transaction-timeline reference model.
module tb_cpu_insn_arbiter;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        r0v, r0Rdy, r1v, r1Rdy;
    logic [31:0] r0i, r1i;
    logic [4:0]  r0r, r1r;
    logic [31:0] cpuInsn, cpuRdData, rspData;
    logic        cpuInsnEn, cpuRdEn, rspValid, rspId, busy;
    logic [4:0]  cpuRdSel;

    logic        bR0v, bR0Rdy, bR1v, bR1Rdy;
    logic [31:0] bR0i, bR1i;
    logic [4:0]  bR0r, bR1r;
    logic [31:0] bInsn, bRdData, bRspData;
    logic        bInsnEn, bRdEn, bRspValid, bRspId, bBusy;
    logic [4:0]  bRdSel;

    int passCnt = 0;
    int totalCnt = 0;

    cpu_insn_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_insn(r0i), .req0_rd(r0r), .req0_ready(r0Rdy),
        .req1_valid(r1v), .req1_insn(r1i), .req1_rd(r1r), .req1_ready(r1Rdy),
        .cpu_insn(cpuInsn), .cpu_insn_en(cpuInsnEn),
        .cpu_rd_sel(cpuRdSel), .cpu_rd_en(cpuRdEn), .cpu_rd_data(cpuRdData),
        .rsp_valid(rspValid), .rsp_id(rspId), .rsp_data(rspData), .busy(busy)
    );

    cpu_insn_arbiter #(.LATENCY(1)) dutL1 (
        .clk(clk), .reset(reset),
        .req0_valid(bR0v), .req0_insn(bR0i), .req0_rd(bR0r), .req0_ready(bR0Rdy),
        .req1_valid(bR1v), .req1_insn(bR1i), .req1_rd(bR1r), .req1_ready(bR1Rdy),
        .cpu_insn(bInsn), .cpu_insn_en(bInsnEn),
        .cpu_rd_sel(bRdSel), .cpu_rd_en(bRdEn), .cpu_rd_data(bRdData),
        .rsp_valid(bRspValid), .rsp_id(bRspId), .rsp_data(bRspData), .busy(bBusy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        r0v = 0; r0i = 0; r0r = 0; r1v = 0; r1i = 0; r1r = 0; cpuRdData = 0;
        bR0v = 0; bR0i = 0; bR0r = 0; bR1v = 0; bR1i = 0; bR1r = 0; bRdData = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        r0v = 1; r1v = 1; bR0v = 1;
        repeat (3) step();
        @(negedge clk);
        totalCnt++;
        if ({r0Rdy, r1Rdy, cpuInsnEn, cpuRdEn, rspValid, rspId, busy} !== 7'b0)
            $display("FAIL reset_ctrl got %b want 0",
                     {r0Rdy, r1Rdy, cpuInsnEn, cpuRdEn, rspValid, rspId, busy});
        else passCnt++;
        totalCnt++;
        if ({cpuInsn, cpuRdSel, rspData} !== 69'b0)
            $display("FAIL reset_data got %h want 0", {cpuInsn, cpuRdSel, rspData});
        else passCnt++;
        totalCnt++;
        if ({bR0Rdy, bR1Rdy, bInsnEn, bRdEn, bRspValid, bBusy, bRspData} !== 38'b0)
            $display("FAIL reset_l1 got %h want 0",
                     {bR0Rdy, bR1Rdy, bInsnEn, bRdEn, bRspValid, bBusy, bRspData});
        else passCnt++;
        clearInputs();
        step();
        reset = 1;
        step();
    endtask

    task automatic test_single();
        r1v = 1; r1i = 32'hF0800123; r1r = 5'd2;
        @(negedge clk);
        totalCnt++;
        if ({r0Rdy, r1Rdy} !== 2'b01)
            $display("FAIL single_ready got %b want 01", {r0Rdy, r1Rdy});
        else passCnt++;
        step();
        r1v = 0; r1i = 0;
        for (int k = 1; k <= 10; k++) begin
            cpuRdData = (k == 8) ? 32'd1 : $urandom;
            @(negedge clk);
            totalCnt++;
            if ({cpuInsnEn, cpuRdEn, rspValid, busy} !== {k == 1, k == 8, k == 9, k <= 9})
                $display("FAIL single_timing k=%0d got %b want %b", k,
                         {cpuInsnEn, cpuRdEn, rspValid, busy},
                         {k == 1, k == 8, k == 9, k <= 9});
            else passCnt++;
            if (k == 1) begin
                totalCnt++;
                if (cpuInsn !== 32'hF0800123)
                    $display("FAIL single_insn got %h want f0800123", cpuInsn);
                else passCnt++;
            end
            if (k == 8) begin
                totalCnt++;
                if (cpuRdSel !== 5'd2)
                    $display("FAIL single_sel got %0d want 2", cpuRdSel);
                else passCnt++;
            end
            if (k == 9) begin
                totalCnt++;
                if ({rspId, rspData} !== {1'b1, 32'd1})
                    $display("FAIL single_rsp got %h want 100000001", {rspId, rspData});
                else passCnt++;
            end
            if (k == 10) begin
                totalCnt++;
                if (rspData !== 32'd1)
                    $display("FAIL single_hold got %h want 1", rspData);
                else passCnt++;
            end
            step();
        end
    endtask

    task automatic test_tie();
        int gCyc[$];
        int gId[$];
        int enCnt;
        int bothRdy;
        int r1Seen;
        reset = 0;
        step();
        reset = 1;
        r0v = 1; r0i = 32'hAAAA0000; r0r = 5'd4;
        r1v = 1; r1i = 32'hBBBB0000; r1r = 5'd5;
        enCnt = 0; bothRdy = 0; r1Seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (r0Rdy || r1Rdy) begin
                gCyc.push_back(c);
                gId.push_back(r1Rdy ? 1 : 0);
            end
            if (r0Rdy && r1Rdy) bothRdy++;
            if (r1Rdy) r1Seen++;
            if (cpuInsnEn) enCnt++;
            step();
        end
        r0v = 0; r1v = 0;
        totalCnt++;
        if (gId.size() != 4 || bothRdy != 0)
            $display("FAIL tie_count got %0d grants %0d both want 4 0", gId.size(), bothRdy);
        else passCnt++;
        totalCnt++;
        if (enCnt != 4)
            $display("FAIL tie_insn_en got %0d want 4", enCnt);
        else passCnt++;
        for (int i = 0; i < gId.size(); i++) begin
            int expId;
`ifdef ARB_ROUND_ROBIN_EN
            expId = i % 2;
`else
            expId = 0;
`endif
            totalCnt++;
            if (gId[i] != expId || gCyc[i] != i * (LAT + 4))
                $display("FAIL tie_grant%0d got id %0d cyc %0d want id %0d cyc %0d",
                         i, gId[i], gCyc[i], expId, i * (LAT + 4));
            else passCnt++;
        end
`ifndef ARB_ROUND_ROBIN_EN
        totalCnt++;
        if (r1Seen != 0)
            $display("FAIL tie_starve got %0d want 0", r1Seen);
        else passCnt++;
`endif
        repeat (LAT + 4) step();
    endtask

    task automatic test_busy();
        r1v = 1; r1i = 32'h11112222; r1r = 5'd9;
        step();
        r1v = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                r0v = 1; r0i = 32'hC0DE0003; r0r = 5'd7;
            end
            if (k == 11) r0v = 0;
            @(negedge clk);
            if (k >= 3 && k <= 10) begin
                totalCnt++;
                if (r0Rdy !== (k == 10))
                    $display("FAIL busy_ready k=%0d got %b want %b", k, r0Rdy, k == 10);
                else passCnt++;
            end
            if (k == 11) begin
                totalCnt++;
                if ({cpuInsnEn, cpuInsn} !== {1'b1, 32'hC0DE0003})
                    $display("FAIL busy_issue got %h want 1c0de0003", {cpuInsnEn, cpuInsn});
                else passCnt++;
            end
            step();
        end
        repeat (10) step();
    endtask

    task automatic test_mid_reset();
        int sawRsp;
        r0v = 1; r0i = 32'hD00D0001; r0r = 5'd3;
        step();
        r0v = 0;
        repeat (3) step();
        reset = 0;
        step();
        @(negedge clk);
        totalCnt++;
        if ({busy, cpuInsnEn, cpuRdEn, rspValid, rspId, r0Rdy, r1Rdy} !== 7'b0)
            $display("FAIL midrst_ctrl got %b want 0",
                     {busy, cpuInsnEn, cpuRdEn, rspValid, rspId, r0Rdy, r1Rdy});
        else passCnt++;
        totalCnt++;
        if ({cpuInsn, cpuRdSel, rspData} !== 69'b0)
            $display("FAIL midrst_data got %h want 0", {cpuInsn, cpuRdSel, rspData});
        else passCnt++;
        step();
        reset = 1;
        sawRsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rspValid || busy) sawRsp++;
            step();
        end
        totalCnt++;
        if (sawRsp != 0)
            $display("FAIL midrst_abort got %0d want 0", sawRsp);
        else passCnt++;
    endtask

    task automatic test_latency1();
        bR0v = 1; bR0i = 32'hE0000005; bR0r = 5'd3;
        @(negedge clk);
        totalCnt++;
        if (bR0Rdy !== 1'b1)
            $display("FAIL l1_ready got %b want 1", bR0Rdy);
        else passCnt++;
        step();
        bR0v = 0;
        for (int k = 1; k <= 6; k++) begin
            bRdData = (k == 3) ? 32'h5A : $urandom;
            @(negedge clk);
            totalCnt++;
            if ({bInsnEn, bRdEn, bRspValid, bBusy} !== {k == 1, k == 3, k == 4, k <= 4})
                $display("FAIL l1_timing k=%0d got %b want %b", k,
                         {bInsnEn, bRdEn, bRspValid, bBusy},
                         {k == 1, k == 3, k == 4, k <= 4});
            else passCnt++;
            if (k == 4) begin
                totalCnt++;
                if ({bRspId, bRspData, bRdSel} !== {1'b0, 32'h5A, 5'd0})
                    $display("FAIL l1_rsp got %h want 5a", {bRspId, bRspData});
                else passCnt++;
            end
            step();
        end
    endtask

    task automatic test_random();
        int freeAt, accCyc, off;
        logic accId, ptrM, acc0, acc1, e0, e1, idle;
        logic [31:0] accInsn, readVal, expData;
        logic [4:0] accRd;
        logic expEn, expRd, expRsp, expBusy;
        reset = 0;
        clearInputs();
        step();
        reset = 1;
        freeAt = 0; accCyc = -1000; accId = 0; ptrM = 0;
        acc0 = 0; acc1 = 0; accInsn = 0; accRd = 0; readVal = 0; expData = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(r0v && !acc0)) begin
                r0v = ($urandom % 3) == 0; r0i = $urandom; r0r = 5'($urandom);
            end else if ($urandom % 10 == 0) r0v = 0;
            if (!(r1v && !acc1)) begin
                r1v = ($urandom % 3) == 0; r1i = $urandom; r1r = 5'($urandom);
            end else if ($urandom % 10 == 0) r1v = 0;
            cpuRdData = $urandom;
            @(negedge clk);
            idle = cyc >= freeAt;
`ifdef ARB_ROUND_ROBIN_EN
            e1 = idle && r1v && (!r0v || ptrM);
`else
            e1 = idle && r1v && !r0v;
`endif
            e0 = idle && r0v && !e1;
            totalCnt++;
            if ({r0Rdy, r1Rdy} !== {e0, e1})
                $display("FAIL rnd_ready c=%0d got %b want %b", cyc, {r0Rdy, r1Rdy}, {e0, e1});
            else passCnt++;
            off = cyc - accCyc;
            expEn = off == 1;
            expRd = off == LAT + 2;
            expRsp = off == LAT + 3;
            expBusy = off >= 1 && off <= LAT + 3;
            if (expRd) readVal = cpuRdData;
            if (expRsp) expData = readVal;
            totalCnt++;
            if ({cpuInsnEn, cpuRdEn, rspValid, busy} !== {expEn, expRd, expRsp, expBusy})
                $display("FAIL rnd_ctrl c=%0d got %b want %b", cyc,
                         {cpuInsnEn, cpuRdEn, rspValid, busy}, {expEn, expRd, expRsp, expBusy});
            else passCnt++;
            totalCnt++;
            if ({cpuInsn, cpuRdSel} !== {expEn ? accInsn : 32'h0, expRd ? accRd : 5'h0})
                $display("FAIL rnd_cpu c=%0d got %h want %h", cyc, {cpuInsn, cpuRdSel},
                         {expEn ? accInsn : 32'h0, expRd ? accRd : 5'h0});
            else passCnt++;
            totalCnt++;
            if ({rspId, rspData} !== {expRsp ? accId : 1'b0, expData})
                $display("FAIL rnd_rsp c=%0d got %h want %h", cyc, {rspId, rspData},
                         {expRsp ? accId : 1'b0, expData});
            else passCnt++;
            acc0 = e0;
            acc1 = e1;
            if (e0 || e1) begin
                accCyc = cyc;
                freeAt = cyc + LAT + 4;
                accId = e1;
                accInsn = e1 ? r1i : r0i;
                accRd = e1 ? r1r : r0r;
                ptrM = ~e1;
            end
            step();
        end
        clearInputs();
        repeat (LAT + 4) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_busy();
        test_mid_reset();
        test_latency1();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
